// File: rtl/div_mod_pkg.sv
// Shared types and helpers for the time-multiplexed divide/modulo scheduler.
// The optional divide-by-zero flag port is controlled by DIV_MOD_SCHED_DZ_FLAG_EN.
package div_mod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // All-ones error value of the given width, returned in a 32-bit container.
  function automatic logic [31:0] DIV_ZERO_QUOT(input int unsigned width);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [31:0] DIV_ZERO_REM(input int unsigned width);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Pointer that gives the just-served requester the lowest priority.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/div_mod_seq_core.sv
// Iterative restoring divider: loads on start, then produces one quotient bit per
// cycle MSB first; done marks the final iteration, with quot/rem showing its result.
module div_mod_seq_core #(
  parameter int NUM_W = 16,
  parameter int DEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quot,
  output logic [DEN_W-1:0] rem
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic             run_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [DEN_W-1:0] den_reg;
  logic [NUM_W-1:0] quot_reg;
  logic [DEN_W-1:0] rem_reg;

  logic [DEN_W:0]   partial;
  logic [DEN_W:0]   diff;
  logic             fits;
  logic [NUM_W-1:0] quot_next;
  logic [DEN_W-1:0] rem_next;

  // quot_reg starts as the numerator; its MSB is consumed as quotient bits shift in.
  always_comb begin
    partial   = {rem_reg, quot_reg[NUM_W-1]};
    diff      = partial - {1'b0, den_reg};
    fits      = (partial >= {1'b0, den_reg});
    rem_next  = fits ? diff[DEN_W-1:0] : partial[DEN_W-1:0];
    quot_next = {quot_reg[NUM_W-2:0], fits};
  end

  assign done = run_reg && (cnt_reg == CNT_W'(NUM_W - 1));
  assign quot = quot_next;
  assign rem  = rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg  <= 1'b0;
      cnt_reg  <= '0;
      den_reg  <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
    end else if (start) begin
      run_reg  <= 1'b1;
      cnt_reg  <= '0;
      den_reg  <= den;
      quot_reg <= num;
      rem_reg  <= '0;
    end else if (run_reg) begin
      quot_reg <= quot_next;
      rem_reg  <= rem_next;
      cnt_reg  <= cnt_reg + 1'b1;
      if (done) run_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/div_mod_sched.sv
// Round-robin scheduler sharing one iterative divider among NUM_REQ requesters.
// Define DIV_MOD_SCHED_DZ_FLAG_EN to add the rsp_dz divide-by-zero flag output.
module div_mod_sched
  import div_mod_pkg::*;
#(
  parameter int NUM_W   = 16,
  parameter int DEN_W   = 8,
  parameter int NUM_REQ = 2,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*NUM_W-1:0] req_num,
  input  logic [NUM_REQ*DEN_W-1:0] req_den,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [NUM_W-1:0]         rsp_quot,
  output logic [DEN_W-1:0]         rsp_rem,
  output logic                     busy
`ifdef DIV_MOD_SCHED_DZ_FLAG_EN
  ,
  output logic                     rsp_dz
`endif
);

  localparam logic [NUM_W-1:0] DZ_QUOT = NUM_W'(DIV_ZERO_QUOT(NUM_W));
  localparam logic [DEN_W-1:0] DZ_REM  = DEN_W'(DIV_ZERO_REM(DEN_W));

  state_t            state_reg;
  state_t            state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   grant;
  logic              grant_valid;
  logic [ID_W:0]     idx_w;
  logic [NUM_W-1:0]  sel_num;
  logic [DEN_W-1:0]  sel_den;
  logic              core_start;
  logic              core_done;
  logic [NUM_W-1:0]  core_quot;
  logic [DEN_W-1:0]  core_rem;

  // Scan from the pointer downwards in priority so the closest valid requester wins last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx_w       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_w = {1'b0, rr_ptr_reg} + (ID_W + 1)'(k);
      if (idx_w >= (ID_W + 1)'(NUM_REQ)) idx_w = idx_w - (ID_W + 1)'(NUM_REQ);
      if (req_valid[idx_w[ID_W-1:0]]) begin
        grant       = idx_w[ID_W-1:0];
        grant_valid = 1'b1;
      end
    end
  end

  assign sel_num = req_num[int'(grant) * NUM_W +: NUM_W];
  assign sel_den = req_den[int'(grant) * DEN_W +: DEN_W];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    core_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          req_ready[grant] = 1'b1;
          if (sel_den == '0) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            core_start = 1'b1;
          end
        end
      end
      BUSY: if (core_done) state_next = DONE;
      DONE: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  div_mod_seq_core #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .num   (sel_num),
    .den   (sel_den),
    .done  (core_done),
    .quot  (core_quot),
    .rem   (core_rem)
  );

`ifdef DIV_MOD_SCHED_DZ_FLAG_EN
  logic dz_reg;
  assign rsp_dz = dz_reg;
`else
  logic dz_reg;
  logic dz_unused;
  assign dz_unused = dz_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_quot   <= '0;
      rsp_rem    <= '0;
      rr_ptr_reg <= '0;
      dz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            rsp_id     <= grant;
            rr_ptr_reg <= ID_W'(rr_next(32'(grant), 32'(NUM_REQ)));
            // A zero divisor bypasses the core and answers on the next cycle.
            if (sel_den == '0) begin
              rsp_valid <= 1'b1;
              rsp_quot  <= DZ_QUOT;
              rsp_rem   <= DZ_REM;
              dz_reg    <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (core_done) begin
            rsp_valid <= 1'b1;
            rsp_quot  <= core_quot;
            rsp_rem   <= core_rem;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            dz_reg    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mod_sched.sv
// Directed bench for div_mod_sched; checks rsp_dz too when DIV_MOD_SCHED_DZ_FLAG_EN is defined.
module tb_div_mod_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_num;
  logic [15:0] req_den;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_quot;
  logic [7:0]  rsp_rem;
  logic        busy;
`ifdef DIV_MOD_SCHED_DZ_FLAG_EN
  logic        rsp_dz;
`endif

  int vectors     = 0;
  int miscompares = 0;

  div_mod_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_num   (req_num),
    .req_den   (req_den),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_quot  (rsp_quot),
    .rsp_rem   (rsp_rem),
    .busy      (busy)
`ifdef DIV_MOD_SCHED_DZ_FLAG_EN
    ,
    .rsp_dz    (rsp_dz)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait (bounded) until the accepting edge has passed.
  task automatic issue(input int r, input logic [15:0] n, input logic [7:0] d);
    logic got;
    req_num[r*16 +: 16] = n;
    req_den[r*8 +: 8]   = d;
    req_valid[r]        = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      #1;
      if (req_ready[r]) got = 1'b1;
      tick();
    end
    req_valid[r] = 1'b0;
    check("accept", 32'(got), 32'd1);
  endtask

  // Latency counted in cycles after the accept cycle; 1 means the very next cycle.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input int r, input logic [15:0] n, input logic [7:0] d,
                     input logic [15:0] eq, input logic [7:0] er, input int elat);
    int lat;
    issue(r, n, d);
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(r));
    check({tag, "_quot"}, 32'(rsp_quot), 32'(eq));
    check({tag, "_rem"}, 32'(rsp_rem), 32'(er));
`ifdef DIV_MOD_SCHED_DZ_FLAG_EN
    check({tag, "_dz"}, 32'(rsp_dz), (d == 8'd0) ? 32'd1 : 32'd0);
`endif
    $display("txn %s: req%0d %0d/%0d -> id=%0d quot=0x%0h rem=0x%0h lat=%0d",
             tag, r, n, d, rsp_id, rsp_quot, rsp_rem, lat);
    handshake();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_vdrop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    int ng;
    int nr;
    int grants[4];
    int rids[4];
    logic [15:0] exp_q[2];
    logic [7:0]  exp_r[2];

    rst       = 1'b1;
    req_valid = '0;
    req_num   = '0;
    req_den   = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_quot", 32'(rsp_quot), 32'd0);
    check("rst_rem", 32'(rsp_rem), 32'd0);
    rst = 1'b0;
    tick();

    // Basic divide, divide-by-zero, edge values
    txn("t1", 0, 16'd1000, 8'd7, 16'd142, 8'd6, 17);
    txn("t2", 1, 16'h1234, 8'd0, 16'hFFFF, 8'hFF, 1);
    txn("t5a", 0, 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 17);
    txn("t5b", 1, 16'd5, 8'd200, 16'd0, 8'd5, 17);
    txn("t5c", 0, 16'hFFFF, 8'hFF, 16'h0101, 8'd0, 17);

    // Both requesters continuously valid: grants must alternate starting at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_num   = {16'd200, 16'd100};
    req_den   = {8'd7, 8'd10};
    exp_q[0] = 16'd10;  exp_r[0] = 8'd0;
    exp_q[1] = 16'd28;  exp_r[1] = 8'd4;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    ng = 0;
    nr = 0;
    for (int k = 0; k < 200 && nr < 4; k++) begin
      #1;
      if (req_ready != 2'b00 && ng < 4) begin
        grants[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
      if (rsp_valid) begin
        rids[nr] = int'(rsp_id);
        check("rr_quot", 32'(rsp_quot), 32'(exp_q[rsp_id]));
        check("rr_rem", 32'(rsp_rem), 32'(exp_r[rsp_id]));
        $display("txn rr: id=%0d quot=%0d rem=%0d", rsp_id, rsp_quot, rsp_rem);
        nr++;
      end
      if (nr < 4) tick();
    end
    req_valid = 2'b00;
    tick();
    rsp_ready = 1'b0;
    check("rr_count", 32'(nr), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("rr_grant", (k < ng) ? 32'(grants[k]) : 32'hDEAD, 32'(k % 2));
      check("rr_rspid", (k < nr) ? 32'(rids[k]) : 32'hDEAD, 32'(k % 2));
    end

    // Response stall: outputs hold, no grant while DONE
    issue(1, 16'd1000, 8'd7);
    wait_rsp(lat);
    check("stall_lat", 32'(lat), 32'd17);
    req_num[15:0] = 16'd5;
    req_den[7:0]  = 8'd3;
    req_valid[0]  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_quot", 32'(rsp_quot), 32'd142);
      check("stall_rem", 32'(rsp_rem), 32'd6);
      check("stall_id", 32'(rsp_id), 32'd1);
      check("stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    $display("txn stall: id=%0d quot=%0d rem=%0d held 5 cycles", rsp_id, rsp_quot, rsp_rem);
    handshake();
    #1;
    check("stall_idle", 32'(busy), 32'd0);
    check("stall_vdrop", 32'(rsp_valid), 32'd0);
    check("stall_regrant", 32'(req_ready), 32'd1);
    req_valid[0] = 1'b0;
    tick();
    check("skip_idle", 32'(busy), 32'd0);

    // Reset in the middle of BUSY discards the operation
    issue(1, 16'h4321, 8'd9);
    repeat (3) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (25) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("mid_rst_silent", 32'(seen), 32'd0);

    req_num   = {16'd100, 16'h1234};
    req_den   = {8'd10, 8'h34};
    req_valid = 2'b11;
    #1;
    check("post_rst_prio", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    wait_rsp(lat);
    check("post_rst_lat", 32'(lat), 32'd17);
    check("post_rst_id", 32'(rsp_id), 32'd0);
    check("post_rst_quot", 32'(rsp_quot), 32'd89);
    check("post_rst_rem", 32'(rsp_rem), 32'd32);
    $display("txn post_rst: id=%0d quot=%0d rem=%0d lat=%0d", rsp_id, rsp_quot, rsp_rem, lat);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
